// File: rtl/enigma_flag_encoder.sv
// Single-rotor stepping shift cipher for ASCII capitals; emits one encrypted
// character per key press and flags when a full FLAG_LEN-letter flag is out.
module enigma_flag_encoder #(
  parameter int unsigned ALPHA_SIZE = 26,
  parameter logic [7:0]  ORD_BASE   = 8'd65,
  parameter int unsigned FLAG_LEN   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       key_press,
  input  logic       set_rotor,
  input  logic [4:0] rotor_init,
  output logic [7:0] enc_out,
  output logic       enc_valid,
  output logic [4:0] rotor_pos,
  output logic [1:0] char_count,
  output logic       flag_done
);

  localparam logic [8:0] Alpha9   = 9'(ALPHA_SIZE);
  localparam logic [4:0] Alpha5   = 5'(ALPHA_SIZE);
  localparam logic [4:0] RotorMax = 5'(ALPHA_SIZE - 1);
  localparam logic [1:0] FlagCnt  = 2'(FLAG_LEN);
  localparam logic [8:0] LetterLo = {1'b0, ORD_BASE};
  localparam logic [8:0] LetterHi = LetterLo + Alpha9 - 9'd1;

  typedef enum logic [1:0] {StIdle, StEncrypt, StWaitRelease} state_t;

  state_t     state;
  logic [7:0] char_reg;

  logic       is_capital;
  logic [8:0] char_wide;
  logic [8:0] shift_sum;
  logic [8:0] shift_mod;
  logic [7:0] enc_char;
  logic [4:0] rotor_next;
  logic [4:0] rotor_load;
  logic [1:0] count_next;

  // Letter arithmetic is done in 9 bits so the offset+rotor sum (max 50) never wraps.
  always_comb begin
    char_wide  = {1'b0, char_reg};
    is_capital = (char_wide >= LetterLo) && (char_wide <= LetterHi);
    shift_sum  = (char_wide - LetterLo) + {4'd0, rotor_pos};
    shift_mod  = (shift_sum >= Alpha9) ? (shift_sum - Alpha9) : shift_sum;
    enc_char   = is_capital ? 8'(LetterLo + shift_mod) : char_reg;
    rotor_next = (rotor_pos == RotorMax) ? 5'd0 : (rotor_pos + 5'd1);
    rotor_load = (rotor_init >= Alpha5) ? (rotor_init - Alpha5) : rotor_init;
    count_next = (char_count == FlagCnt) ? char_count : (char_count + 2'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      char_reg   <= 8'd0;
      enc_out    <= 8'd0;
      enc_valid  <= 1'b0;
      rotor_pos  <= 5'd0;
      char_count <= 2'd0;
    end else begin
      enc_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (set_rotor) begin
            rotor_pos  <= rotor_load;
            char_count <= 2'd0;
          end else if (key_press) begin
            char_reg <= char_in;
            state    <= StEncrypt;
          end
        end
        StEncrypt: begin
          enc_out   <= enc_char;
          enc_valid <= 1'b1;
          // Non-letters pass through without consuming a rotor step.
          if (is_capital) begin
            rotor_pos  <= rotor_next;
            char_count <= count_next;
          end
          state <= StWaitRelease;
        end
        StWaitRelease: begin
          if (!key_press) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign flag_done = (char_count == FlagCnt);

endmodule
